fifo_param: RTL

Parametrised synchronous FIFO that succeeds the fixed 32-bit buffer used between producer and consumer stages. It adds configurable width and depth, full/empty and programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags, a read-valid strobe and a synchronous flush. It is a drop-in replacement on the existing write port (`di`/`wen`) and read port (`dout`/`ren`), with the same one-cycle registered read latency.

---
 rtl/fifo_param.sv | 96 +++++++++
 1 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a synchronous flush.
//
// Transfer semantics: a write is taken on a rising edge when wen is high and
// the FIFO is not full, or a read is taken in the same edge. A read is taken
// when ren is high and the FIFO is not empty. Its data appears on dout with
// dout_valid high for the whole following cycle. flush overrides both
// requests. There is no fall-through, so a read of an empty FIFO is rejected
// even when a write arrives in the same cycle.
module fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         di,
  input  logic                     wen,
  input  logic                     ren,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic rd_acc;
  logic wr_acc;

  // Status is decoded from the pointer registers only, never from inputs.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= PW'(AF_LEVEL));
  assign almost_empty = (count <= PW'(AE_LEVEL));

  // A read frees a slot, so a full FIFO can still take a simultaneous write.
  assign rd_acc = ren && !empty && !flush;
  assign wr_acc = wen && (!full || (ren && !empty)) && !flush;

  // Pointers, read data register and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        dout <= mem[rptr[AW-1:0]];
        rptr <= rptr + 1'b1;
      end
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (wen && full && !(ren && !empty)) begin
        overflow <= 1'b1;
      end
      if (ren && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[AW-1:0]] <= di;
    end
  end

endmodule
